// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types for the write-back queue in front of the 8x16 register file.
//   wb_kind_e  : operation carried by a queued result (write/swap/bit-set/bit-clear)
//   wb_entry_t : one queued result {kind, addr, bitpos, data}
//   BITOP_*    : encodings driven on rf_bit_op
// Entry widths are fixed here and must match the register file geometry.
// -----------------------------------------------------------------------------
package wb_pkg;

  localparam int WB_DATA_W   = 16;
  localparam int WB_ADDR_W   = 3;
  localparam int WB_NUM_REGS = 1 << WB_ADDR_W;

  localparam logic [1:0] BITOP_SET = 2'b00;
  localparam logic [1:0] BITOP_CLR = 2'b01;

  typedef enum logic [1:0] {
    WB_DATA = 2'b00,
    WB_SWAP = 2'b01,
    WB_BSET = 2'b10,
    WB_BCLR = 2'b11
  } wb_kind_e;

  typedef struct packed {
    wb_kind_e               kind;
    logic [WB_ADDR_W-1:0]   addr;
    logic [3:0]             bitpos;
    logic [WB_DATA_W-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t with a combinational head.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_entry this cycle (ignored when full and not popping)
//   push_entry  : entry to enqueue
//   pop         : drop the head this cycle (ignored when empty)
//   head        : oldest entry, valid whenever !empty
//   full, empty : occupancy flags
//   count       : number of stored entries, 0..DEPTH
// Pointers are log2(DEPTH) bits and wrap naturally, so DEPTH must be a power of 2.
// -----------------------------------------------------------------------------
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only safe when the head leaves in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
// Write-back stage in front of the 8x16 register file. Merges ALU and load
// results into one in-order queue, retires one entry per cycle onto the
// register-file write port and exports a per-register pending mask for
// RAW-hazard stalls in decode.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   alu_valid/alu_ready              : ALU result handshake
//   alu_kind/addr/data/bitpos        : ALU result (kind 00 write, 01 swap,
//                                      10 bit set, 11 bit clear)
//   mem_valid/mem_ready              : load result handshake (always a write)
//   mem_addr/mem_data                : load result
//   rf_write_en                      : head entry presented this cycle
//   rf_swap_en/rf_bit_op_en          : operation qualifiers for the head
//   rf_bit_op/rf_bit_position        : bit-op encoding and bit index
//   rf_write_addr/rf_data_in         : target register and write data
//   pending[r]                       : at least one queued entry targets r
//   empty                            : queue holds no entries
// Every output is forced low while rst_n is low, readies included.
// DATA_W/ADDR_W must match the entry widths fixed in wb_pkg.
// -----------------------------------------------------------------------------
module writeback_queue
  import wb_pkg::*;
#(
  parameter  int DATA_W = WB_DATA_W,
  parameter  int ADDR_W = WB_ADDR_W,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [1:0]        alu_kind,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [3:0]        alu_bitpos,

  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,

  output logic              rf_write_en,
  output logic              rf_swap_en,
  output logic              rf_bit_op_en,
  output logic [1:0]        rf_bit_op,
  output logic [3:0]        rf_bit_position,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_data_in,

  output logic [7:0]        pending,
  output logic              empty
);

  localparam int SUM_W = CNT_W + WB_ADDR_W;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic             push;
  logic             pop;
  logic             mem_take;
  logic             alu_take;

  logic [CNT_W-1:0] cnt_q [WB_NUM_REGS];
  logic [CNT_W-1:0] cnt_d [WB_NUM_REGS];
  logic [7:0]       pending_q, pending_d;
  logic [SUM_W-1:0] cnt_sum;

  // ---------------------------------------------------------------------------
  // Acceptance. Readies look only at the registered fill level, never at the
  // same-cycle pop, so a full queue refuses input even while its head retires.
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_ready  = rst_n & ~fifo_full;
    alu_ready  = rst_n & ~fifo_full & ~mem_valid;
    mem_take   = mem_valid & mem_ready;
    alu_take   = alu_valid & alu_ready;
    push       = mem_take | alu_take;
    push_entry = '0;
    if (mem_take) begin
      push_entry.kind = WB_DATA;
      push_entry.addr = mem_addr;
      push_entry.data = mem_data;
    end else if (alu_take) begin
      push_entry.kind   = wb_kind_e'(alu_kind);
      push_entry.addr   = alu_addr;
      push_entry.bitpos = alu_bitpos;
      push_entry.data   = alu_data;
    end
  end

  // The register file always accepts, so the head leaves whenever present.
  assign pop = ~fifo_empty;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Head decode onto the register-file port; fields the kind does not use
  // are held at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    rf_write_en     = 1'b0;
    rf_swap_en      = 1'b0;
    rf_bit_op_en    = 1'b0;
    rf_bit_op       = 2'b00;
    rf_bit_position = 4'd0;
    rf_write_addr   = '0;
    rf_data_in      = '0;
    if (!fifo_empty) begin
      rf_write_en   = 1'b1;
      rf_write_addr = head.addr;
      case (head.kind)
        WB_DATA: rf_data_in = head.data;
        WB_SWAP: rf_swap_en = 1'b1;
        WB_BSET: begin
          rf_bit_op_en    = 1'b1;
          rf_bit_op       = BITOP_SET;
          rf_bit_position = head.bitpos;
        end
        WB_BCLR: begin
          rf_bit_op_en    = 1'b1;
          rf_bit_op       = BITOP_CLR;
          rf_bit_position = head.bitpos;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Per-register pending counters. Accept and retire on the same register
  // cancel out. The mask is taken from the next-state counts so it is
  // registered alongside them.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int r = 0; r < WB_NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (push && (push_entry.addr == WB_ADDR_W'(r))) begin
        cnt_d[r] = cnt_d[r] + CNT_W'(1);
      end
      if (pop && (head.addr == WB_ADDR_W'(r))) begin
        cnt_d[r] = cnt_d[r] - CNT_W'(1);
      end
      pending_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      for (int r = 0; r < WB_NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending = pending_q;
  assign empty   = rst_n & fifo_empty;

  // ---------------------------------------------------------------------------
  // Bookkeeping invariant: the per-register counts always add up to the
  // queue occupancy, which never exceeds DEPTH.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_sum = '0;
    for (int r = 0; r < WB_NUM_REGS; r++) begin
      cnt_sum = cnt_sum + SUM_W'(cnt_q[r]);
    end
  end

  a_cnt_invariant : assert property (
    @(posedge clk) disable iff (!rst_n)
      (cnt_sum == SUM_W'(fifo_count)) && (fifo_count <= CNT_W'(DEPTH))
  );

endmodule

// File: tb/tb_writeback_queue.sv
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [1:0]  alu_kind;
  logic [2:0]  alu_addr;
  logic [15:0] alu_data;
  logic [3:0]  alu_bitpos;
  logic        mem_valid;
  logic        mem_ready;
  logic [2:0]  mem_addr;
  logic [15:0] mem_data;
  logic        rf_write_en;
  logic        rf_swap_en;
  logic        rf_bit_op_en;
  logic [1:0]  rf_bit_op;
  logic [3:0]  rf_bit_position;
  logic [2:0]  rf_write_addr;
  logic [15:0] rf_data_in;
  logic [7:0]  pending;
  logic        empty;

  writeback_queue #(.DATA_W(16), .ADDR_W(3), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_kind        (alu_kind),
    .alu_addr        (alu_addr),
    .alu_data        (alu_data),
    .alu_bitpos      (alu_bitpos),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_data        (mem_data),
    .rf_write_en     (rf_write_en),
    .rf_swap_en      (rf_swap_en),
    .rf_bit_op_en    (rf_bit_op_en),
    .rf_bit_op       (rf_bit_op),
    .rf_bit_position (rf_bit_position),
    .rf_write_addr   (rf_write_addr),
    .rf_data_in      (rf_data_in),
    .pending         (pending),
    .empty           (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the queue as a plain list of accepted results
  typedef struct {
    int kind;
    int addr;
    int bitpos;
    int data;
  } m_ent_t;

  m_ent_t m_q[$];
  int     n_checks;
  int     n_fail;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit         e_we, e_swap, e_bop_en;
    int         e_bop, e_pos, e_addr, e_data;
    logic [7:0] e_pend;
    e_we = 0; e_swap = 0; e_bop_en = 0;
    e_bop = 0; e_pos = 0; e_addr = 0; e_data = 0;
    e_pend = '0;
    foreach (m_q[i]) e_pend[m_q[i].addr] = 1'b1;
    if (m_q.size() > 0) begin
      e_we   = 1;
      e_addr = m_q[0].addr;
      case (m_q[0].kind)
        0: e_data = m_q[0].data;
        1: e_swap = 1;
        2: begin e_bop_en = 1; e_bop = 0; e_pos = m_q[0].bitpos; end
        default: begin e_bop_en = 1; e_bop = 1; e_pos = m_q[0].bitpos; end
      endcase
    end
    check_eq("rf_write_en",     32'(rf_write_en),     32'(e_we));
    check_eq("rf_swap_en",      32'(rf_swap_en),      32'(e_swap));
    check_eq("rf_bit_op_en",    32'(rf_bit_op_en),    32'(e_bop_en));
    check_eq("rf_bit_op",       32'(rf_bit_op),       32'(e_bop));
    check_eq("rf_bit_position", 32'(rf_bit_position), 32'(e_pos));
    check_eq("rf_write_addr",   32'(rf_write_addr),   32'(e_addr));
    check_eq("rf_data_in",      32'(rf_data_in),      32'(e_data));
    check_eq("pending",         32'(pending),         32'(e_pend));
    check_eq("empty",           32'(empty),           32'(m_q.size() == 0));
  endtask

  // one clock cycle: drive, check against the model, then advance the model
  task automatic step(input bit av, input int ak, input int aa, input int ad, input int ab,
                      input bit mv, input int ma, input int md);
    bit     e_mrdy, e_ardy;
    m_ent_t e;
    @(negedge clk);
    alu_valid  = av;
    alu_kind   = 2'(ak);
    alu_addr   = 3'(aa);
    alu_data   = 16'(ad);
    alu_bitpos = 4'(ab);
    mem_valid  = mv;
    mem_addr   = 3'(ma);
    mem_data   = 16'(md);
    #1;
    e_mrdy = (m_q.size() < DEPTH);
    e_ardy = e_mrdy && !mv;
    check_eq("mem_ready", 32'(mem_ready), 32'(e_mrdy));
    check_eq("alu_ready", 32'(alu_ready), 32'(e_ardy));
    check_outputs();
    @(posedge clk);
    if (m_q.size() > 0) m_q.delete(0);
    if (mv && e_mrdy) begin
      e.kind = 0; e.addr = ma & 7; e.bitpos = 0; e.data = md & 16'hFFFF;
      m_q.push_back(e);
    end else if (av && e_ardy) begin
      e.kind = ak & 3; e.addr = aa & 7; e.bitpos = ab & 15; e.data = ad & 16'hFFFF;
      m_q.push_back(e);
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_outs"},
             32'({alu_ready, mem_ready, rf_write_en, rf_swap_en, rf_bit_op_en,
                  rf_bit_op, rf_bit_position, rf_write_addr}), 32'(0));
    check_eq({tag, "_data"}, 32'(rf_data_in), 32'(0));
    check_eq({tag, "_pend"}, 32'({pending, empty}), 32'(0));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    alu_valid  = 1'b0;
    alu_kind   = '0;
    alu_addr   = '0;
    alu_data   = '0;
    alu_bitpos = '0;
    mem_valid  = 1'b0;
    mem_addr   = '0;
    mem_data   = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("in_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single load r3
    step(0, 0, 0, 0, 0, 1, 3, 16'hBEEF);
    idle();
    idle();

    // ALU and load in the same cycle: load wins, ALU held and taken next
    step(1, 0, 1, 16'h0011, 0, 1, 2, 16'h2222);
    step(1, 0, 1, 16'h0011, 0, 0, 0, 0);
    idle();
    idle();

    // five back-to-back ALU pushes, order through pointer wrap
    for (int i = 0; i < 5; i++) step(1, 0, i, 16'h1000 + i, 0, 0, 0, 0);
    idle();
    idle();

    // swap r5 then bit clear r5 pos 7
    step(1, 1, 5, 16'hFFFF, 0, 0, 0, 0);
    step(1, 3, 5, 0, 7, 0, 0, 0);
    idle();
    idle();

    // push r4 while head r4 retires
    step(1, 0, 4, 16'hAAAA, 0, 0, 0, 0);
    step(1, 0, 4, 16'hBBBB, 0, 0, 0, 0);
    step(1, 2, 4, 0, 15, 0, 0, 0);
    idle();
    idle();

    // reset with an entry in flight and both valids held high
    step(0, 0, 0, 0, 0, 1, 6, 16'h6666);
    @(negedge clk);
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    rst_n     = 1'b0;
    #1;
    check_all_zero("reset_mid");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    @(negedge clk);
    rst_n     = 1'b1;
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    m_q.delete();
    idle();

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
           $urandom & 16'hFFFF, $urandom_range(0, 15),
           $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom & 16'hFFFF);
    end
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
